ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/ifu.sv | 103 ++++++++++
 tb/tb_ifu.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: two-state fetch/issue sequencer with next-PC logic.
// Define IFU_PERF_CNT_EN to add the fetch_cnt accepted-instruction counter.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_accept,
  input  logic [1:0]  NPCOp,
  input  logic [25:0] Imm,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        npc_err
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt
`endif
);

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

  typedef enum logic {FETCH = 1'b0, ISSUE = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, instr_q, npc, pc_seq;
  logic        err_q;
  logic        fetch_done, issue_done;

  assign fetch_done = (state == FETCH) && imem_ack;
  assign issue_done = (state == ISSUE) && instr_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (imem_ack)     state_nxt = ISSUE;
      ISSUE:   if (instr_accept) state_nxt = FETCH;
      default:                   state_nxt = FETCH;
    endcase
  end

  always_comb begin
    imem_req    = (state == FETCH);
    instr_valid = (state == ISSUE);
  end

  // Every NPC source ends in 2'b00, so PC stays word aligned by construction.
  assign pc_seq = pc_q + 32'd4;

  always_comb begin
    npc = pc_seq;
    case (NPCOp)
      NPC_PLUS4:  npc = pc_seq;
      NPC_BRANCH: npc = pc_seq + {{14{Imm[15]}}, Imm[15:0], 2'b00};
      NPC_JUMP:   npc = {pc_seq[31:28], Imm, 2'b00};
      default:    npc = pc_seq;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      if (fetch_done) instr_q <= imem_rdata;
      if (issue_done) begin
        pc_q <= npc;
        if (NPCOp == 2'b11) err_q <= 1'b1;
      end
    end
  end

  assign imem_addr = pc_q;
  assign PC        = pc_q;
  assign PCPlus4   = pc_seq;
  assign instr     = instr_q;
  assign npc_err   = err_q;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt_q <= 32'h0;
    else if (issue_done) cnt_q <= cnt_q + 32'd1;
  end

  assign fetch_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: three instances with different reset PCs share stimulus and
// are compared every cycle against a transaction-level reference model.
module tb_ifu;

  localparam logic [31:0] RPC [3] = '{32'h0000_3000, 32'h4000_0000, 32'hFFFF_FFFC};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_accept = 1'b0;
  logic [1:0]  NPCOp = 2'b00;
  logic [25:0] Imm = 26'h0;

  logic [2:0]       req, vld, err;
  logic [2:0][31:0] addr, pc, pc4, ins;
`ifdef IFU_PERF_CNT_EN
  logic [2:0][31:0] cnt;
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ifu #(.RESET_PC(RPC[g])) u_ifu (
      .clk          (clk),
      .rst          (rst),
      .imem_req     (req[g]),
      .imem_addr    (addr[g]),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .instr        (ins[g]),
      .instr_valid  (vld[g]),
      .instr_accept (instr_accept),
      .NPCOp        (NPCOp),
      .Imm          (Imm),
      .PC           (pc[g]),
      .PCPlus4      (pc4[g]),
      .npc_err      (err[g])
`ifdef IFU_PERF_CNT_EN
      ,
      .fetch_cnt    (cnt[g])
`endif
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: "waiting on memory" flag plus architectural values.
  logic        m_fetch;
  logic [31:0] m_pc [3];
  logic [31:0] m_instr;
  logic        m_err;
  logic [31:0] m_cnt;

  function automatic logic [31:0] ref_npc(input logic [31:0] cur, input logic [1:0] op,
                                          input logic [25:0] imm);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    off = $signed(imm[15:0]);
    case (op)
      2'd1:    return seq + 32'(off * 4);
      2'd2:    return (seq & 32'hF000_0000) | (32'(imm) * 32'd4);
      default: return seq;
    endcase
  endfunction

  task automatic model_reset();
    m_fetch = 1'b1;
    for (int i = 0; i < 3; i++) m_pc[i] = RPC[i];
    m_instr = 32'h0;
    m_err   = 1'b0;
    m_cnt   = 32'h0;
  endtask

  task automatic model_clock(input logic a, input logic [31:0] rd, input logic acc,
                             input logic [1:0] op, input logic [25:0] imm);
    if (m_fetch) begin
      if (a) begin
        m_instr = rd;
        m_fetch = 1'b0;
      end
    end else if (acc) begin
      for (int i = 0; i < 3; i++) m_pc[i] = ref_npc(m_pc[i], op, imm);
      if (op == 2'd3) m_err = 1'b1;
      m_cnt   = m_cnt + 32'd1;
      m_fetch = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s[%0d]: got %h expected %h", tag, idx, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk("imem_req", i, 32'(req[i]), 32'(m_fetch));
      chk("imem_addr", i, addr[i], m_pc[i]);
      chk("pc", i, pc[i], m_pc[i]);
      chk("pcplus4", i, pc4[i], m_pc[i] + 32'd4);
      chk("instr_valid", i, 32'(vld[i]), 32'(!m_fetch));
      chk("instr", i, ins[i], m_instr);
      chk("npc_err", i, 32'(err[i]), 32'(m_err));
`ifdef IFU_PERF_CNT_EN
      chk("fetch_cnt", i, cnt[i], m_cnt);
`endif
    end
  endtask

  // Called at a falling edge; drives one cycle of inputs and advances the model.
  task automatic step(input logic r, input logic a, input logic [31:0] rd, input logic acc,
                      input logic [1:0] op, input logic [25:0] imm);
    rst = r; imem_ack = a; imem_rdata = rd; instr_accept = acc; NPCOp = op; Imm = imm;
    if (r) model_reset();
    #1 check_all();
    @(posedge clk);
    if (!r) model_clock(a, rd, acc, op, imm);
    @(negedge clk);
  endtask

  // Ack every second cycle; a stray accept during the wait must be ignored.
  task automatic fetch(input logic [31:0] rd);
    step(1'b0, 1'b0, 32'h0, 1'b1, 2'b10, 26'h3FF_FFFF);
    step(1'b0, 1'b1, rd, 1'b0, 2'b00, 26'h0);
  endtask

  task automatic accept(input logic [1:0] op, input logic [25:0] imm);
    step(1'b0, 1'b0, 32'h0, 1'b1, op, imm);
  endtask

  initial begin
    logic [31:0] held;
    model_reset();
    #2;
    step(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 26'h0);
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 2'b00, 26'h0);
    chk("rst_addr", 0, addr[0], 32'h0000_3000);
    step(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 26'h0);

    fetch(32'h2008_0005);
    chk("first_instr", 0, ins[0], 32'h2008_0005);
    chk("first_pc4", 0, pc4[0], 32'h0000_3004);
    chk("first_vld", 0, 32'(vld[0]), 32'd1);
    accept(2'b00, 26'h0);
    chk("wrap_addr", 2, addr[2], 32'h0000_0000);
    fetch(32'h1111_2222);
    accept(2'b00, 26'h0);
    chk("pre_rst_addr", 0, addr[0], 32'h0000_3008);

    // Reset mid-fetch with an ack present: takes effect before any clock edge.
    imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA; rst = 1'b1;
    #1;
    chk("async_pc", 0, pc[0], 32'h0000_3000);
    chk("async_instr", 0, ins[0], 32'h0);
    chk("async_vld", 0, 32'(vld[0]), 32'd0);
    step(1'b1, 1'b1, 32'h5555_AAAA, 1'b0, 2'b00, 26'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 26'h0);

    fetch(32'h0800_0C01);
    accept(2'b10, 26'h000_0C01);
    chk("jump_addr", 1, addr[1], 32'h4000_3004);
    for (int k = 0; k < 3; k++) begin
      fetch($urandom);
      accept(2'b00, 26'(k));
    end
    chk("seq_addr", 0, addr[0], 32'h0000_3010);
    fetch($urandom);
    accept(2'b01, 26'h000_FFFF);
    chk("br_back_addr", 0, addr[0], 32'h0000_3010);
`ifdef IFU_PERF_CNT_EN
    chk("cnt5", 0, cnt[0], 32'd5);
`endif
    fetch($urandom);
    accept(2'b01, 26'h3FF_0003);
    chk("br_fwd_addr", 0, addr[0], 32'h0000_3020);

    // Stall in issue with spurious acks.
    fetch(32'hCAFE_F00D);
    held = ins[0];
    for (int k = 0; k < 10; k++) step(1'b0, 1'(k % 2), $urandom, 1'b0, 2'($urandom), 26'($urandom));
    chk("hold_instr", 0, ins[0], held);
    chk("hold_pc", 0, pc[0], 32'h0000_3020);
    chk("hold_req", 0, 32'(req[0]), 32'd0);

    accept(2'b11, 26'($urandom));
    chk("rsvd_addr", 0, addr[0], 32'h0000_3024);
    chk("rsvd_err", 0, 32'(err[0]), 32'd1);
    fetch($urandom);
    accept(2'b00, 26'h0);
    chk("err_sticky", 0, 32'(err[0]), 32'd1);

    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 39) == 0), 1'($urandom), $urandom, 1'($urandom),
           2'($urandom), 26'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
